// File: rtl/alu_exec_stage.sv
// alu_exec_stage: single-issue 4-bit execute stage with operand forwarding
// from its own write port and a 4-cycle iterative shift-add multiplier.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready; non-MUL ops complete in one cycle, MUL is latched
// ST_MUL   | one shift-add step per cycle, write port loaded on last step
module alu_exec_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs1,
    input  logic [1:0] in_rs2,
    input  logic [3:0] in_imm,
    output logic [1:0] rf_rd_addr1,
    output logic [1:0] rf_rd_addr2,
    input  logic [3:0] rf_rd_data1,
    input  logic [3:0] rf_rd_data2,
    output logic       rf_wr_en,
    output logic [1:0] rf_wr_addr,
    output logic [3:0] rf_wr_data,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LI  = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t     state_q,    state_d;
    logic [1:0] cnt_q,      cnt_d;      // MUL steps remaining after this one
    logic [7:0] acc_q,      acc_d;
    logic [7:0] mcand_q,    mcand_d;
    logic [3:0] mplier_q,   mplier_d;
    logic [1:0] mul_rd_q,   mul_rd_d;
    logic       wr_en_q,    wr_en_d;
    logic [1:0] wr_addr_q,  wr_addr_d;
    logic [3:0] wr_data_q,  wr_data_d;
    logic       zero_q,     zero_d;
    logic       carry_q,    carry_d;

    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [4:0] sum5;
    logic [4:0] diff5;
    logic [7:0] acc_step;
    logic       accept;

    assign rf_rd_addr1 = in_rs1;
    assign rf_rd_addr2 = in_rs2;

    // The register file only sees our write on the next edge, so a pending
    // write to a source register is bypassed here.
    assign op_a = (wr_en_q && (wr_addr_q == in_rs1)) ? wr_data_q : rf_rd_data1;
    assign op_b = (wr_en_q && (wr_addr_q == in_rs2)) ? wr_data_q : rf_rd_data2;

    assign sum5     = {1'b0, op_a} + {1'b0, op_b};
    assign diff5    = {1'b0, op_a} - {1'b0, op_b};   // bit 4 is the borrow
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : 8'd0);

    assign in_ready = !reset && (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == ST_MUL);

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;

    // Next-state, datapath and write-port computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        mul_rd_d  = mul_rd_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        zero_d    = zero_q;
        carry_d   = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (in_op)
                        OP_ADD: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = in_rd;
                            wr_data_d = sum5[3:0];
                            zero_d    = (sum5[3:0] == 4'd0);
                            carry_d   = sum5[4];
                        end
                        OP_SUB: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = in_rd;
                            wr_data_d = diff5[3:0];
                            zero_d    = (diff5[3:0] == 4'd0);
                            carry_d   = diff5[4];
                        end
                        OP_AND: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = in_rd;
                            wr_data_d = op_a & op_b;
                            zero_d    = ((op_a & op_b) == 4'd0);
                            carry_d   = 1'b0;
                        end
                        OP_OR: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = in_rd;
                            wr_data_d = op_a | op_b;
                            zero_d    = ((op_a | op_b) == 4'd0);
                            carry_d   = 1'b0;
                        end
                        OP_XOR: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = in_rd;
                            wr_data_d = op_a ^ op_b;
                            zero_d    = ((op_a ^ op_b) == 4'd0);
                            carry_d   = 1'b0;
                        end
                        OP_LI: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = in_rd;
                            wr_data_d = in_imm;
                            zero_d    = (in_imm == 4'd0);
                        end
                        OP_MUL: begin
                            state_d  = ST_MUL;
                            cnt_d    = 2'd3;
                            acc_d    = 8'd0;
                            mcand_d  = {4'd0, op_a};
                            mplier_d = op_b;
                            mul_rd_d = in_rd;
                        end
                        OP_NOP: begin
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = {mcand_q[6:0], 1'b0};
                mplier_d = {1'b0, mplier_q[3:1]};
                if (cnt_q == 2'd0) begin
                    state_d   = ST_IDLE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = mul_rd_q;
                    wr_data_d = acc_step[3:0];
                    zero_d    = (acc_step[3:0] == 4'd0);
                    carry_d   = (acc_step[7:4] != 4'd0);
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset also discards any MUL in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            acc_q     <= 8'd0;
            mcand_q   <= 8'd0;
            mplier_q  <= 4'd0;
            mul_rd_q  <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 2'd0;
            wr_data_q <= 4'd0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            mul_rd_q  <= mul_rd_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: directed scenarios followed by random
// instruction streams, checked against an architectural model in which each
// instruction sees the results of all earlier ones.
module tb_alu_exec_stage;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_LI  = 5;
    localparam int OP_MUL = 6;
    localparam int OP_NOP = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic [3:0] in_imm;
    logic [1:0] rf_rd_addr1;
    logic [1:0] rf_rd_addr2;
    logic [3:0] rf_rd_data1;
    logic [3:0] rf_rd_data2;
    logic       rf_wr_en;
    logic [1:0] rf_wr_addr;
    logic [3:0] rf_wr_data;
    logic       flag_zero;
    logic       flag_carry;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // architectural model state
    int mrf [4] = '{default: 0};
    bit m_z = 1'b0;
    bit m_c = 1'b0;
    int m_wa = 0;
    int m_wd = 0;

    // instruction staged onto the inputs while a MUL iterates
    int nx_op = OP_NOP, nx_rd = 0, nx_rs1 = 0, nx_rs2 = 0, nx_imm = 0;

    logic [3:0] rf_arr [4] = '{default: 4'd0};

    always #5 clk = ~clk;

    // Register file: combinational read, write sampled on the rising edge.
    assign rf_rd_data1 = rf_arr[rf_rd_addr1];
    assign rf_rd_data2 = rf_arr[rf_rd_addr2];
    always @(posedge clk) if (rf_wr_en) rf_arr[rf_wr_addr] <= rf_wr_data;

    alu_exec_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Architectural result of one instruction using the model register file.
    task automatic model_exec(input int op, input int rs1, input int rs2, input int imm,
                              output bit wr, output int res, output bit nz, output bit nc);
        int a;
        int b;
        int t;
        a   = mrf[rs1];
        b   = mrf[rs2];
        wr  = 1'b1;
        res = 0;
        nz  = m_z;
        nc  = m_c;
        case (op)
            OP_ADD: begin t = a + b; res = t % 16; nc = (t > 15); end
            OP_SUB: begin res = (a - b + 16) % 16; nc = (a < b); end
            OP_AND: begin res = a & b; nc = 1'b0; end
            OP_OR:  begin res = a | b; nc = 1'b0; end
            OP_XOR: begin res = a ^ b; nc = 1'b0; end
            OP_LI:  begin res = imm; end
            OP_MUL: begin t = a * b; res = t % 16; nc = (t > 15); end
            default: wr = 1'b0;
        endcase
        if (wr) nz = (res == 0);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_wr_en"}, 8'(rf_wr_en), 8'(0));
        chk({tag, "_wr_addr_hold"}, 8'(rf_wr_addr), 8'(m_wa));
        chk({tag, "_wr_data_hold"}, 8'(rf_wr_data), 8'(m_wd));
        chk({tag, "_zero_hold"}, 8'(flag_zero), 8'(m_z));
        chk({tag, "_carry_hold"}, 8'(flag_carry), 8'(m_c));
    endtask

    // Offer one instruction at a falling edge, let it be accepted, then check
    // its write/flags in the cycle it must appear. Returns on the falling edge
    // of that cycle; with keep=1 in_valid is left asserted for the caller.
    task automatic do_op(input int op, input int rd, input int rs1, input int rs2,
                         input int imm, input bit keep);
        bit wr;
        int res;
        bit nz;
        bit nc;
        in_valid = 1'b1;
        in_op    = 3'(op);
        in_rd    = 2'(rd);
        in_rs1   = 2'(rs1);
        in_rs2   = 2'(rs2);
        in_imm   = 4'(imm);
        chk("ready_at_offer", 8'(in_ready), 8'(1));
        model_exec(op, rs1, rs2, imm, wr, res, nz, nc);
        @(posedge clk);
        @(negedge clk);
        if (op == OP_MUL) begin
            for (int i = 0; i < 4; i++) begin
                if (keep) begin
                    in_valid = 1'b1;
                    in_op    = 3'(nx_op);
                    in_rd    = 2'(nx_rd);
                    in_rs1   = 2'(nx_rs1);
                    in_rs2   = 2'(nx_rs2);
                    in_imm   = 4'(nx_imm);
                end else begin
                    in_valid = 1'($urandom);
                    in_op    = 3'($urandom);
                    in_rd    = 2'($urandom);
                    in_rs1   = 2'($urandom);
                    in_rs2   = 2'($urandom);
                    in_imm   = 4'($urandom);
                end
                chk("mul_busy", 8'(busy), 8'(1));
                chk("mul_ready_low", 8'(in_ready), 8'(0));
                check_outputs("mul_iter");
                @(negedge clk);
            end
        end
        if (wr) begin
            mrf[rd] = res;
            m_wa    = rd;
            m_wd    = res;
        end
        m_z = nz;
        m_c = nc;
        chk("wr_en", 8'(rf_wr_en), 8'(wr));
        chk("wr_addr", 8'(rf_wr_addr), 8'(m_wa));
        chk("wr_data", 8'(rf_wr_data), 8'(m_wd));
        chk("flag_zero", 8'(flag_zero), 8'(m_z));
        chk("flag_carry", 8'(flag_carry), 8'(m_c));
        chk("busy_done", 8'(busy), 8'(0));
        chk("ready_done", 8'(in_ready), 8'(1));
        if (!keep) in_valid = 1'b0;
    endtask

    // One cycle with nothing offered and garbage on the ignored fields.
    task automatic idle_cycle();
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_rd    = 2'($urandom);
        in_rs1   = 2'($urandom);
        in_rs2   = 2'($urandom);
        in_imm   = 4'($urandom);
        @(negedge clk);
        check_outputs("idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c_op, c_rd, c_rs1, c_rs2, c_imm;
        int n_op, n_rd, n_rs1, n_rs2, n_imm;
        bit keep;

        // reset with an instruction offered: it must be dropped
        reset    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'(OP_LI);
        in_rd    = 2'd3;
        in_rs1   = 2'd0;
        in_rs2   = 2'd0;
        in_imm   = 4'd5;
        @(negedge clk);
        chk("rst_ready_low", 8'(in_ready), 8'(0));
        @(negedge clk);
        chk("rst_wr_en", 8'(rf_wr_en), 8'(0));
        chk("rst_wr_addr", 8'(rf_wr_addr), 8'(0));
        chk("rst_wr_data", 8'(rf_wr_data), 8'(0));
        chk("rst_zero", 8'(flag_zero), 8'(0));
        chk("rst_carry", 8'(flag_carry), 8'(0));
        chk("rst_busy", 8'(busy), 8'(0));
        chk("rst_ready_low2", 8'(in_ready), 8'(0));
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("post_rst_ready", 8'(in_ready), 8'(1));
        @(negedge clk);
        chk("dropped_no_write", 8'(rf_wr_en), 8'(0));

        // LI then dependent ADD back-to-back
        do_op(OP_LI, 1, 0, 0, 7, 1'b1);
        chk("li_r1_7", 8'(rf_wr_data), 8'd7);
        do_op(OP_ADD, 2, 1, 1, 0, 1'b0);
        chk("fwd_add_14", 8'(rf_wr_data), 8'd14);
        chk("fwd_add_addr", 8'(rf_wr_addr), 8'd2);
        idle_cycle();

        // ADD carry, SUB borrow, SUB to zero
        do_op(OP_LI, 1, 0, 0, 9, 1'b1);
        do_op(OP_LI, 2, 0, 0, 8, 1'b1);
        do_op(OP_ADD, 3, 1, 2, 0, 1'b1);
        chk("add_wrap_1", 8'(rf_wr_data), 8'd1);
        chk("add_carry", 8'(flag_carry), 8'd1);
        do_op(OP_SUB, 0, 2, 1, 0, 1'b1);
        chk("sub_15", 8'(rf_wr_data), 8'd15);
        chk("sub_borrow", 8'(flag_carry), 8'd1);
        do_op(OP_SUB, 0, 1, 1, 0, 1'b1);
        chk("sub_zero_val", 8'(rf_wr_data), 8'd0);
        chk("sub_zero_flag", 8'(flag_zero), 8'd1);
        chk("sub_zero_carry", 8'(flag_carry), 8'd0);

        // NOP after carry-producing ADD keeps flags
        do_op(OP_ADD, 3, 1, 2, 0, 1'b1);
        do_op(OP_NOP, 0, 0, 0, 0, 1'b0);
        chk("nop_no_write", 8'(rf_wr_en), 8'd0);
        chk("nop_carry_kept", 8'(flag_carry), 8'd1);
        idle_cycle();

        // MUL 5*3 and 15*15
        do_op(OP_LI, 1, 0, 0, 5, 1'b1);
        do_op(OP_LI, 2, 0, 0, 3, 1'b1);
        do_op(OP_MUL, 3, 1, 2, 0, 1'b0);
        chk("mul_15", 8'(rf_wr_data), 8'd15);
        chk("mul_15_carry", 8'(flag_carry), 8'd0);
        do_op(OP_LI, 1, 0, 0, 15, 1'b1);
        do_op(OP_LI, 2, 0, 0, 15, 1'b1);
        do_op(OP_MUL, 0, 1, 2, 0, 1'b0);
        chk("mul_225_low", 8'(rf_wr_data), 8'd1);
        chk("mul_225_carry", 8'(flag_carry), 8'd1);

        // ADD held valid during MUL, accepted in C5 reading the MUL result
        nx_op = OP_ADD; nx_rd = 2; nx_rs1 = 1; nx_rs2 = 1; nx_imm = 0;
        do_op(OP_MUL, 1, 1, 2, 0, 1'b1);
        do_op(OP_ADD, 2, 1, 1, 0, 1'b0);
        chk("add_after_mul", 8'(rf_wr_data), 8'd2);
        idle_cycle();

        // reset in C2 of a MUL aborts it
        do_op(OP_LI, 1, 0, 0, 3, 1'b1);
        do_op(OP_LI, 2, 0, 0, 2, 1'b0);
        idle_cycle();
        in_valid = 1'b1;
        in_op    = 3'(OP_MUL);
        in_rd    = 2'd3;
        in_rs1   = 2'd1;
        in_rs2   = 2'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_busy_c1", 8'(busy), 8'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", 8'(rf_wr_en), 8'(0));
        chk("abort_zero", 8'(flag_zero), 8'(0));
        chk("abort_carry", 8'(flag_carry), 8'(0));
        chk("abort_busy", 8'(busy), 8'(0));
        chk("abort_ready_in_rst", 8'(in_ready), 8'(0));
        reset = 1'b0;
        m_z = 1'b0; m_c = 1'b0; m_wa = 0; m_wd = 0;
        #1;
        chk("abort_ready_after", 8'(in_ready), 8'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_write", 8'(rf_wr_en), 8'(0));
        end
        chk("abort_r3_intact", 8'(rf_arr[3]), 8'(mrf[3]));
        do_op(OP_ADD, 0, 3, 3, 0, 1'b0);
        idle_cycle();

        // random instruction stream, mixing back-to-back issue and gaps
        c_op = $urandom_range(7); c_rd = $urandom_range(3); c_rs1 = $urandom_range(3);
        c_rs2 = $urandom_range(3); c_imm = $urandom_range(15);
        for (int k = 0; k < 200; k++) begin
            n_op = $urandom_range(7); n_rd = $urandom_range(3); n_rs1 = $urandom_range(3);
            n_rs2 = $urandom_range(3); n_imm = $urandom_range(15);
            keep = 1'($urandom);
            nx_op = n_op; nx_rd = n_rd; nx_rs1 = n_rs1; nx_rs2 = n_rs2; nx_imm = n_imm;
            do_op(c_op, c_rd, c_rs1, c_rs2, c_imm, keep);
            if (!keep) idle_cycle();
            c_op = n_op; c_rd = n_rd; c_rs1 = n_rs1; c_rs2 = n_rs2; c_imm = n_imm;
        end
        in_valid = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 4; r++) chk("final_rf", 8'(rf_arr[r]), 8'(mrf[r]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  instruction offered; in_ready  out  1  stage can accept.
REQ-004 SHALL have: in_op  in  3  opcode; in_rd  in  2  dest reg; in_rs1/in_rs2  in  2 each  source regs; in_imm  in  4  immediate.
REQ-005 SHALL have: rf_rd_addr1/rf_rd_addr2  out  2 each  register-file read addresses; rf_rd_data1/rf_rd_data2  in  4 each  combinational read data.
REQ-006 SHALL have: rf_wr_en  out  1; rf_wr_addr  out  2; rf_wr_data  out  4  register-file write port, sampled by the file on the next rising edge.
REQ-007 SHALL have: flag_zero  out  1; flag_carry  out  1; busy  out  1  (high while a MUL iterates).

Function
REQ-008 SHALL decode in_op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LI (result=in_imm), 110 MUL, 111 NOP.
REQ-009 SHALL accept an instruction at a rising edge where in_valid && in_ready; in_ready = !reset && state==IDLE.
REQ-010 SHALL drive rf_rd_addr1=in_rs1, rf_rd_addr2=in_rs2 combinationally at all times.
REQ-011 SHALL forward: operand N = rf_wr_data if rf_wr_en && rf_wr_addr==in_rsN, else rf_rd_dataN (covers write-then-read in the same cycle).
REQ-012 SHALL compute all results mod 16 (4-bit); ADD carry = bit 4 of 5-bit sum; SUB result = rs1-rs2 mod 16, carry = borrow (rs1<rs2 unsigned).
REQ-013 Non-MUL ops accepted in cycle C0: rf_wr_en=1 with rf_wr_addr=in_rd, rf_wr_data=result for exactly cycle C1; NOP gives rf_wr_en=0 in C1.
REQ-014 SHALL implement FSM states IDLE and MUL; IDLE->MUL on accepted MUL; MUL->IDLE after exactly 4 cycles.
REQ-015 MUL SHALL latch forwarded operands and rd at accept, perform one shift-add step per cycle in C1..C4, busy=1 and in_ready=0 in C1..C4.
REQ-016 MUL SHALL present rf_wr_en=1, low 4 bits of the 8-bit product, rf_wr_addr=latched rd in C5; in_ready=1 in C5.
REQ-017 Flags SHALL update on the same edge that loads the write port: zero=(result==0) for all ops except NOP; carry per REQ-012 for ADD/SUB, 0 for AND/OR/XOR, (product[7:4]!=0) for MUL, unchanged for LI; NOP leaves both flags unchanged.
REQ-018 rf_wr_en SHALL be 0 in every cycle not specified by REQ-013/REQ-016; rf_wr_addr/rf_wr_data hold last values when rf_wr_en=0.
REQ-019 An instruction accepted in C1 (non-MUL) or C5 (MUL) SHALL see the pending write via REQ-011 (back-to-back dependency, no stall).
REQ-020 in_op/in_rd/in_rs*/in_imm SHALL be ignored when not accepting; in_valid while in_ready=0 SHALL cause no state change.

Reset
REQ-021 reset=1 at a rising edge SHALL set state=IDLE, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, flag_zero=0, flag_carry=0, busy=0.
REQ-022 reset during MUL iteration SHALL abort it; no write for that MUL occurs, ever.
REQ-023 reset SHALL override a simultaneous accept; the offered instruction is dropped.
REQ-024 in_ready SHALL be 0 combinationally while reset=1.

Verification
REQ-025 LI r1,7 then ADD r2,r1,r1 back-to-back -> C1: wr r1=7; C2: wr r2=14 (forwarded), zero=0, carry=0.
REQ-026 r1=9,r2=8; ADD r3,r1,r2 -> wr r3=1, carry=1; SUB r0,r2,r1 -> wr r0=15, carry=1; SUB r0,r1,r1 -> wr 0, zero=1, carry=0.
REQ-027 r1=5,r2=3; MUL r3,r1,r2 -> in_ready=0/busy=1 for 4 cycles, C5 wr r3=15, carry=0; r1=15,r2=15 -> wr 1, carry=1.
REQ-028 in_valid held high with ADDs during MUL -> none accepted until C5; first ADD accepted in C5 reads MUL result via forwarding.
REQ-029 reset asserted in C2 of a MUL -> rf_wr_en stays 0 through C6, flags=0, in_ready=1 the cycle after reset deasserts.
REQ-030 NOP after ADD producing carry=1 -> rf_wr_en=0, flags unchanged (carry=1).
